vector_fetch_unit: RTL
======================

// Module: vector_fetch_unit
// PURPOSE
//  Upstream feeder of program_counter. On reset, NMI, IRQ or BRK it reads the
//  two-byte vector from memory, then drives PCL/PCH and a one-cycle load strobe.
//  It also holds PC increment off while it owns the address bus.
//  Stack pushes of PC/P are done by the control sequencer before it raises a request.
// PARAMETERS
//  NMI_VEC    16'hFFFA  NMI vector address (low byte; high byte at +1)
//  RESET_VEC  16'hFFFC  reset vector address
//  IRQ_VEC    16'hFFFE  IRQ/BRK vector address
// PORTS
//  clk            in   1   system clock, rising edge
//  reset_n        in   1   asynchronous, active-low reset
//  nmi_n          in   1   NMI pin, falling-edge sensitive, already synchronised
//  irq_n          in   1   IRQ pin, level sensitive, active-low, already synchronised
//  i_flag         in   1   P.I interrupt-disable bit
//  brk_req        in   1   decoder pulse: BRK executed, push done
//  instr_boundary in   1   pulse on the last cycle of each instruction
//  data_in        in   8   memory read data, valid the cycle after addr is driven
//  addr           out  16  vector byte address
//  addr_valid     out  1   this block owns the address bus
//  pcl_out        out  8   value for program_counter PCL_in
//  pch_out        out  8   value for program_counter PCH_in
//  pc_load        out  1   load strobe to program_counter
//  inc_inhibit    out  1   forces program_counter inc_enable low
//  set_i_flag     out  1   pulse: set P.I
//  vector_taken   out  2   00 none, 01 RESET, 10 NMI, 11 IRQ/BRK; valid with pc_load
// BEHAVIOUR
//  Reset values: state IDLE, reset_pending=1, nmi_pending=0, all outputs 0.
//  States:
//   IDLE      -> FETCH_LO when a request is accepted
//   FETCH_LO  addr=VEC
//   FETCH_HI  addr=VEC+1; capture data_in as lo_byte at the cycle end
//   LOAD      pcl_out=lo_byte, pch_out=data_in (combinational pass-through),
//             pc_load=1, set_i_flag=1, vector_taken valid -> IDLE
//  addr_valid=inc_inhibit=1 in FETCH_LO, FETCH_HI and LOAD.
//  addr, pcl_out and pch_out read 0 whenever they are not valid.
//  Latency: request accepted at edge T -> FETCH_LO in cycle T+1.
//   PC holds the vector in cycle T+4.
//  Acceptance in IDLE, in priority order:
//   1. reset_pending: accepted unconditionally, no instr_boundary needed.
//   2. nmi_pending: accepted on instr_boundary.
//   3. (!irq_n && !i_flag) || brk_req: accepted on instr_boundary.
//      BRK ignores i_flag.
//  NMI edge detect:
//   - nmi_n 1->0, compared against a registered copy, sets nmi_pending.
//   - nmi_pending clears on entry to FETCH_LO for an NMI.
//   - An edge arriving while busy stays pending.
//  NMI hijack:
//   - Applies when an edge (or nmi_pending) is present during FETCH_LO of an
//     IRQ/BRK.
//   - FETCH_HI then uses NMI_VEC+1 and the lo byte refetch restarts at FETCH_LO
//     with NMI_VEC.
//   - Result: vector_taken=10.
//  IRQ is level-sensitive: it is not latched, so a release before the boundary
//  drops it. A losing IRQ stays asserted and is retaken at the next boundary.
//  instr_boundary and brk_req are ignored while not IDLE.
//  reset_n low mid-sequence aborts immediately.
//   After release, the first edge enters FETCH_LO with RESET_VEC.
//  Address wrap: VEC+1 uses 16-bit arithmetic.
//   Example: a vector parameter of FFFF gives high address 0000.
// STRUCTURE
//  Shared package cpu_pkg:
//   - typedef enum vec_state_t {IDLE, FETCH_LO, FETCH_HI, LOAD}
//   - vector_taken codes as localparams
//   - default vector constants
//  One sub-module: nmi_edge_latch (edge detect + pending flag, clear input).
//  The FSM, lo_byte register and address mux live in the top level.
// TESTING
//  Release reset; memory FFFC=3F, FFFD=FE
//   -> addr FFFC then FFFD; pc_load 3 edges after release.
//   -> PCL=3F, PCH=FE; vector_taken=01.
//  IDLE, i_flag=0, irq_n low at boundary; FFFE=00, FFFF=80
//   -> PC=8000, set_i_flag pulse, vector_taken=11.
//  irq_n low with i_flag=1 over 3 boundaries
//   -> no addr_valid, inc_inhibit stays 0.
//  nmi_n falls mid-instruction; irq_n low at the same boundary
//   -> NMI_VEC taken first (FFFA/FFFB), then IRQ at the next boundary.
//  brk_req at boundary, nmi_n falls during FETCH_LO
//   -> addr refetches FFFA, FFFB; vector_taken=10.
//  reset_n low during FETCH_HI of an IRQ
//   -> outputs 0 at once; after release, reset vector fetched.
//   -> No stale pc_load.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and constants.
// Vector fetch states, vector codes and default vector addresses.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH_LO,
        FETCH_HI,
        LOAD
    } vec_state_t;

    localparam logic [1:0] VT_NONE  = 2'b00;
    localparam logic [1:0] VT_RESET = 2'b01;
    localparam logic [1:0] VT_NMI   = 2'b10;
    localparam logic [1:0] VT_IRQ   = 2'b11;

    localparam logic [15:0] DEF_NMI_VEC   = 16'hFFFA;
    localparam logic [15:0] DEF_RESET_VEC = 16'hFFFC;
    localparam logic [15:0] DEF_IRQ_VEC   = 16'hFFFE;

endpackage

// File: rtl/nmi_edge_latch.sv
// NMI falling-edge detector with a sticky pending flag.
// Clear wins over a coincident edge: that edge is the one being consumed.
module nmi_edge_latch (
    input  logic clk,
    input  logic reset_n,
    input  logic i_nmi_n,
    input  logic i_clr,
    output logic o_edge,
    output logic o_pending
);

    logic r_nmi_prev;
    logic r_pending;

    assign o_edge    = r_nmi_prev & ~i_nmi_n;
    assign o_pending = r_pending;

    // Track the previous pin level and hold an edge until serviced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_nmi_prev <= 1'b1;
            r_pending  <= 1'b0;
        end else begin
            r_nmi_prev <= i_nmi_n;
            if (i_clr) begin
                r_pending <= 1'b0;
            end else if (o_edge) begin
                r_pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/vector_fetch_unit.sv
// Fetches the RESET/NMI/IRQ/BRK vector and loads it into the PC.
// An NMI seen during the IRQ low-byte fetch redirects to the NMI vector.
module vector_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [15:0] NMI_VEC   = DEF_NMI_VEC,
    parameter logic [15:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [15:0] IRQ_VEC   = DEF_IRQ_VEC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        nmi_n,
    input  logic        irq_n,
    input  logic        i_flag,
    input  logic        brk_req,
    input  logic        instr_boundary,
    input  logic [7:0]  data_in,
    output logic [15:0] addr,
    output logic        addr_valid,
    output logic [7:0]  pcl_out,
    output logic [7:0]  pch_out,
    output logic        pc_load,
    output logic        inc_inhibit,
    output logic        set_i_flag,
    output logic [1:0]  vector_taken
);

    vec_state_t  r_state;
    vec_state_t  w_state_nxt;
    logic [1:0]  r_vec_sel;
    logic [1:0]  w_vec_sel_nxt;
    logic        r_reset_pending;
    logic        w_reset_pending_nxt;
    logic [7:0]  r_lo_byte;
    logic [15:0] w_vec_base;
    logic        w_nmi_edge;
    logic        w_nmi_pending;
    logic        w_nmi_clr;
    logic        w_nmi_req;
    logic        w_irq_req;

    nmi_edge_latch u_nmi (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_nmi_n   (nmi_n),
        .i_clr     (w_nmi_clr),
        .o_edge    (w_nmi_edge),
        .o_pending (w_nmi_pending)
    );

    assign w_nmi_req = w_nmi_pending | w_nmi_edge;
    assign w_irq_req = (~irq_n & ~i_flag) | brk_req;

    // State, selected vector and reset-pending registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= IDLE;
            r_vec_sel       <= VT_NONE;
            r_reset_pending <= 1'b1;
        end else begin
            r_state         <= w_state_nxt;
            r_vec_sel       <= w_vec_sel_nxt;
            r_reset_pending <= w_reset_pending_nxt;
        end
    end

    // Low vector byte arrives during FETCH_HI.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_lo_byte <= 8'h00;
        end else if (r_state == FETCH_HI) begin
            r_lo_byte <= data_in;
        end
    end

    // Request acceptance, NMI redirect and sequencing.
    always_comb begin
        w_state_nxt         = r_state;
        w_vec_sel_nxt       = r_vec_sel;
        w_reset_pending_nxt = r_reset_pending;
        w_nmi_clr           = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_reset_pending) begin
                    w_state_nxt         = FETCH_LO;
                    w_vec_sel_nxt       = VT_RESET;
                    w_reset_pending_nxt = 1'b0;
                end else if (instr_boundary && w_nmi_req) begin
                    w_state_nxt   = FETCH_LO;
                    w_vec_sel_nxt = VT_NMI;
                    w_nmi_clr     = 1'b1;
                end else if (instr_boundary && w_irq_req) begin
                    w_state_nxt   = FETCH_LO;
                    w_vec_sel_nxt = VT_IRQ;
                end
            end
            FETCH_LO: begin
                if (r_vec_sel == VT_IRQ && w_nmi_req) begin
                    w_vec_sel_nxt = VT_NMI;
                    w_nmi_clr     = 1'b1;
                end else begin
                    w_state_nxt = FETCH_HI;
                end
            end
            FETCH_HI: w_state_nxt = LOAD;
            LOAD:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    // Vector base address for the sequence in progress.
    always_comb begin
        w_vec_base = 16'h0000;
        unique case (r_vec_sel)
            VT_RESET: w_vec_base = RESET_VEC;
            VT_NMI:   w_vec_base = NMI_VEC;
            VT_IRQ:   w_vec_base = IRQ_VEC;
            default:  w_vec_base = 16'h0000;
        endcase
    end

    // Bus and PC-load outputs; everything reads zero when not valid.
    always_comb begin
        addr         = 16'h0000;
        addr_valid   = 1'b0;
        inc_inhibit  = 1'b0;
        pcl_out      = 8'h00;
        pch_out      = 8'h00;
        pc_load      = 1'b0;
        set_i_flag   = 1'b0;
        vector_taken = VT_NONE;
        unique case (r_state)
            FETCH_LO: begin
                addr        = w_vec_base;
                addr_valid  = 1'b1;
                inc_inhibit = 1'b1;
            end
            FETCH_HI: begin
                addr        = w_vec_base + 16'd1;
                addr_valid  = 1'b1;
                inc_inhibit = 1'b1;
            end
            LOAD: begin
                addr_valid   = 1'b1;
                inc_inhibit  = 1'b1;
                pcl_out      = r_lo_byte;
                pch_out      = data_in;
                pc_load      = 1'b1;
                set_i_flag   = 1'b1;
                vector_taken = r_vec_sel;
            end
            default: ;
        endcase
    end

endmodule
